// File: rtl/sail_ex_mem_pkg.sv
// Shared constants for the EX/MEM skid stage: control-bundle bit positions,
// FSM state encoding and the packed entry width.
package sail_ex_mem_pkg;

    localparam int unsigned CTL_REGWRITE = 0;
    localparam int unsigned CTL_MEMREAD  = 1;
    localparam int unsigned CTL_MEMWRITE = 2;
    localparam int unsigned CTL_MEMTOREG = 3;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Entry = {alu_out, store_data, rd, ctl}; branch info is consumed at accept.
    function automatic int unsigned entry_w(input int unsigned data_w,
                                            input int unsigned reg_w,
                                            input int unsigned ctl_w);
        return 2 * data_w + reg_w + ctl_w;
    endfunction

    localparam int unsigned ENTRY_W = entry_w(32, 5, 4);

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with an increment strobe; holds at all-ones.
module perf_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline stage: 2-entry skid buffer, taken-branch redirect pulse and
// EX-to-EX forwarding tap. Define EX_MEM_SKID_PERF_EN to enable perf counters.
module ex_mem_skid_stage
    import sail_ex_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CTL_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic              in_branch_en,
    input  logic              in_is_branch,
    input  logic [DATA_W-1:0] in_branch_tgt,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [CTL_W-1:0]  in_ctl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_out,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_rd,
    output logic [CTL_W-1:0]  out_ctl,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_redirect_cnt
);

    localparam int unsigned EW = entry_w(DATA_W, REG_W, CTL_W);

    logic [1:0]    state_q, state_d;
    logic [EW-1:0] head_q, skid_q, in_entry;
    logic          in_ready_q;
    logic          redir_q;
    logic [DATA_W-1:0] redir_pc_q;

    logic accept, drain, take_branch;
    logic load_head_in, load_head_skid, load_skid;

    assign in_entry    = {in_alu_out, in_store_data, in_rd, in_ctl};
    assign accept      = in_valid & in_ready_q;
    assign drain       = out_valid & out_ready;
    assign take_branch = accept & in_is_branch & in_branch_en & ~flush;

    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // A coincident drain is still seen downstream via out_valid/out_ready.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_ONE;
                        load_head_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (accept && drain) begin
                        load_head_in = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_d        = ST_ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            skid_q     <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
            if (load_head_in) begin
                head_q <= in_entry;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
            redir_q <= take_branch;
            if (take_branch) begin
                redir_pc_q <= in_branch_tgt;
            end
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = (state_q != ST_EMPTY);
    assign {out_alu_out, out_store_data, out_rd, out_ctl} = head_q;
    assign redirect_valid = redir_q;
    assign redirect_pc    = redir_pc_q;

    // Loads never forward: the value is an address, not the loaded data.
    assign fwd_valid = out_valid & out_ctl[CTL_REGWRITE] & ~out_ctl[CTL_MEMREAD]
                     & (out_rd != '0);
    assign fwd_rd    = out_rd;
    assign fwd_data  = out_alu_out;

`ifdef EX_MEM_SKID_PERF_EN
    perf_sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid & ~out_ready),
        .count (perf_stall_cnt)
    );

    perf_sat_counter #(.WIDTH(32)) u_redirect_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redir_q),
        .count (perf_redirect_cnt)
    );
`else
    assign perf_stall_cnt    = '0;
    assign perf_redirect_cnt = '0;
`endif

endmodule
